t03_dpu_regbank: RTL and testbench

Parametrised MMIO register bank between the CPU data bus and the display processing unit (DPU). It decodes bus writes and reads for a global control word plus NUM_PLAYERS per-player status and position words. Each field has a shadow copy and an active copy: shadow fields are bus-visible, and active fields drive the DPU. Shadow-to-active transfer is either immediate or synchronised to a frame boundary (vsync), so the DPU never draws a half-updated frame.

---
 rtl/t03_dpu_regbank_if.sv | 19 +
 rtl/t03_dpu_regbank.sv | 170 +++++++++++++++++
 tb/tb_t03_dpu_regbank.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/t03_dpu_regbank_if.sv
// CPU data-bus bundle for the DPU register bank: request, address, data and ack.
interface t03_dpu_regbank_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (
      output wr_en, rd_en, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/t03_dpu_regbank.sv
// DPU MMIO register bank. Bus-visible shadow registers feed active registers
// that drive the DPU. Shadow-to-active commit happens on every write in
// immediate mode, or once per frame at the vsync rise in frame-sync mode.
module t03_dpu_regbank #(
   parameter int          NUM_PLAYERS = 2,
   parameter int          COORD_W     = 11,
   parameter int          HEALTH_W    = 4,
   parameter logic [31:0] BASE_ADDR   = 32'hFF00_0000
) (
   input  logic                            clk,
   input  logic                            nrst,
   t03_dpu_regbank_if.slave                bus,
   input  logic                            vsync,
   output logic [2:0]                      game_state,
   output logic [2*NUM_PLAYERS-1:0]        p_state,
   output logic [HEALTH_W*NUM_PLAYERS-1:0] p_health,
   output logic [NUM_PLAYERS-1:0]          p_left,
   output logic [COORD_W*NUM_PLAYERS-1:0]  p_x,
   output logic [COORD_W*NUM_PLAYERS-1:0]  p_y,
   output logic                            dirty,
   output logic                            frame_sync_mode
);

   localparam int NUM_WORDS = 1 + 2*NUM_PLAYERS;

   typedef struct packed {
      logic [1:0]          state;
      logic [HEALTH_W-1:0] health;
      logic                left;
      logic [COORD_W-1:0]  x;
      logic [COORD_W-1:0]  y;
   } player_t;

   typedef struct packed {
      logic [2:0]                       game_state;
      player_t [NUM_PLAYERS-1:0]        pl;
   } bank_t;

   bank_t       shadow_q, shadow_d;
   bank_t       active_q, active_d;
   logic        mode_q, mode_d;
   logic        dirty_q, dirty_d;
   logic        vsync_q;
   logic [31:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;

   logic [29:0] off;
   logic        hit;
   logic        wr_hit;
   logic        rd_hit;
   logic        force_commit;
   logic        post_commit;
   logic        vs_commit;

   // Address decode: word offset from the base, aligned and in range only.
   always_comb begin
      off          = 30'((bus.addr - BASE_ADDR) >> 2);
      hit          = (bus.addr[1:0] == 2'b00) && (off < 30'(NUM_WORDS));
      wr_hit       = bus.wr_en && hit;
      // a simultaneous write wins; the read is dropped
      rd_hit       = bus.rd_en && !bus.wr_en && hit;
      force_commit = wr_hit && (off == 30'd0) && bus.wdata[1];
      ack_d        = hit && (bus.wr_en || bus.rd_en);
   end

   // Shadow update from bus writes; the mode bit has no shadow copy.
   always_comb begin
      shadow_d = shadow_q;
      mode_d   = mode_q;
      if (wr_hit) begin
         if (off == 30'd0) begin
            shadow_d.game_state = bus.wdata[30:28];
            mode_d              = bus.wdata[0];
         end
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (off == 30'(1 + 2*p)) begin
               shadow_d.pl[p].state  = bus.wdata[27:26];
               shadow_d.pl[p].health = bus.wdata[16 +: HEALTH_W];
               shadow_d.pl[p].left   = bus.wdata[0];
            end
            if (off == 30'(2 + 2*p)) begin
               shadow_d.pl[p].x = bus.wdata[16 +: COORD_W];
               shadow_d.pl[p].y = bus.wdata[0 +: COORD_W];
            end
         end
      end
   end

   // Commit control: write-driven commits see the post-write shadow, a vsync
   // commit sees the pre-write shadow so a coincident write stays pending.
   always_comb begin
      post_commit = (wr_hit && !mode_q) || force_commit;
      vs_commit   = mode_q && vsync && !vsync_q;
      active_d    = active_q;
      dirty_d     = dirty_q;
      if (post_commit) begin
         active_d = shadow_d;
         dirty_d  = 1'b0;
      end else if (vs_commit) begin
         active_d = shadow_q;
         dirty_d  = wr_hit;
      end else if (wr_hit && mode_q) begin
         dirty_d  = 1'b1;
      end
      // immediate mode never reports pending data
      if (!mode_d) begin
         dirty_d = 1'b0;
      end
   end

   // Read mux over the shadow copy; rdata holds when there is no read hit.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_hit) begin
         rdata_d = '0;
         if (off == 30'd0) begin
            rdata_d[30:28] = shadow_q.game_state;
            rdata_d[1]     = dirty_q;
            rdata_d[0]     = mode_q;
         end
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (off == 30'(1 + 2*p)) begin
               rdata_d[27:26]           = shadow_q.pl[p].state;
               rdata_d[16 +: HEALTH_W]  = shadow_q.pl[p].health;
               rdata_d[0]               = shadow_q.pl[p].left;
            end
            if (off == 30'(2 + 2*p)) begin
               rdata_d[16 +: COORD_W]   = shadow_q.pl[p].x;
               rdata_d[0 +: COORD_W]    = shadow_q.pl[p].y;
            end
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         shadow_q <= '0;
         active_q <= '0;
         mode_q   <= 1'b0;
         dirty_q  <= 1'b0;
         vsync_q  <= 1'b0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         mode_q   <= mode_d;
         dirty_q  <= dirty_d;
         vsync_q  <= vsync;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
      end
   end

   assign game_state      = active_q.game_state;
   assign dirty           = dirty_q;
   assign frame_sync_mode = mode_q;
   assign bus.rdata       = rdata_q;
   assign bus.ack         = ack_q;

   for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : gen_players
      assign p_state[2*gi +: 2]              = active_q.pl[gi].state;
      assign p_health[HEALTH_W*gi +: HEALTH_W] = active_q.pl[gi].health;
      assign p_left[gi]                      = active_q.pl[gi].left;
      assign p_x[COORD_W*gi +: COORD_W]      = active_q.pl[gi].x;
      assign p_y[COORD_W*gi +: COORD_W]      = active_q.pl[gi].y;
   end

endmodule

// File: tb/tb_t03_dpu_regbank.sv
// Directed, table-driven bench for t03_dpu_regbank (default parameters).
module tb_t03_dpu_regbank;
   localparam logic [31:0] B = 32'hFF00_0000;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        vsync = 1'b0;
   logic [2:0]  game_state;
   logic [3:0]  p_state;
   logic [7:0]  p_health;
   logic [1:0]  p_left;
   logic [21:0] p_x;
   logic [21:0] p_y;
   logic        dirty;
   logic        frame_sync_mode;

   t03_dpu_regbank_if bus ();

   t03_dpu_regbank dut (
      .clk             (clk),
      .nrst            (nrst),
      .bus             (bus.slave),
      .vsync           (vsync),
      .game_state      (game_state),
      .p_state         (p_state),
      .p_health        (p_health),
      .p_left          (p_left),
      .p_x             (p_x),
      .p_y             (p_y),
      .dirty           (dirty),
      .frame_sync_mode (frame_sync_mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        vs;
      logic        ack;
      logic [31:0] rdata;
      logic [2:0]  gs;
      logic [3:0]  pst;
      logic [7:0]  phl;
      logic [1:0]  plf;
      logic [21:0] px;
      logic [21:0] py;
      logic        dirty;
      logic        mode;
   } vec_t;

   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic wr, input logic rd, input logic [31:0] a,
                      input logic [31:0] wd, input logic vs, input logic eack,
                      input logic [31:0] erd, input logic [2:0] egs,
                      input logic [3:0] epst, input logic [7:0] ephl,
                      input logic [1:0] eplf, input logic [21:0] epx,
                      input logic [21:0] epy, input logic edirty, input logic emode);
      vec_t v;
      v = '{wr, rd, a, wd, vs, eack, erd, egs, epst, ephl, eplf, epx, epy, edirty, emode};
      vecs.push_back(v);
   endtask

   task automatic check_all(input string tag, input vec_t v);
      chk({tag, " ack"},   32'(bus.ack),         32'(v.ack));
      chk({tag, " rdata"}, bus.rdata,            v.rdata);
      chk({tag, " gs"},    32'(game_state),      32'(v.gs));
      chk({tag, " pst"},   32'(p_state),         32'(v.pst));
      chk({tag, " phl"},   32'(p_health),        32'(v.phl));
      chk({tag, " plf"},   32'(p_left),          32'(v.plf));
      chk({tag, " px"},    32'(p_x),             32'(v.px));
      chk({tag, " py"},    32'(p_y),             32'(v.py));
      chk({tag, " dirty"}, 32'(dirty),           32'(v.dirty));
      chk({tag, " mode"},  32'(frame_sync_mode), 32'(v.mode));
   endtask

   task automatic drive(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic vs);
      bus.wr_en = wr;
      bus.rd_en = rd;
      bus.addr  = a;
      bus.wdata = wd;
      vsync     = vs;
   endtask

   initial begin
      vec_t zero_v;
      //   wr rd addr    wdata          vs ack rdata          gs pst   phl    plf    px         py         dty md
      add(0, 1, B+0,  32'h0,         0, 1, 32'h0,         0, 4'h0, 8'h00, 2'b00, 22'h0,     22'h0,     0, 0);
      add(0, 1, B+4,  32'h0,         0, 1, 32'h0,         0, 4'h0, 8'h00, 2'b00, 22'h0,     22'h0,     0, 0);
      add(0, 1, B+8,  32'h0,         0, 1, 32'h0,         0, 4'h0, 8'h00, 2'b00, 22'h0,     22'h0,     0, 0);
      add(0, 1, B+12, 32'h0,         0, 1, 32'h0,         0, 4'h0, 8'h00, 2'b00, 22'h0,     22'h0,     0, 0);
      add(0, 1, B+16, 32'h0,         0, 1, 32'h0,         0, 4'h0, 8'h00, 2'b00, 22'h0,     22'h0,     0, 0);
      // mode 0: immediate commit of player 0 position
      add(1, 0, B+8,  32'h0A0B0C0D,  0, 1, 32'h0,         0, 4'h0, 8'h00, 2'b00, 22'h20B,   22'h40D,   0, 0);
      add(0, 1, B+8,  32'h0,         0, 1, 32'h020B040D,  0, 4'h0, 8'h00, 2'b00, 22'h20B,   22'h40D,   0, 0);
      add(0, 0, B+0,  32'h0,         0, 0, 32'h020B040D,  0, 4'h0, 8'h00, 2'b00, 22'h20B,   22'h40D,   0, 0);
      // enter frame-sync mode, pend a status write, commit on vsync rise
      add(1, 0, B+0,  32'h1,         0, 1, 32'h020B040D,  0, 4'h0, 8'h00, 2'b00, 22'h20B,   22'h40D,   0, 1);
      add(1, 0, B+12, 32'h08030001,  0, 1, 32'h020B040D,  0, 4'h0, 8'h00, 2'b00, 22'h20B,   22'h40D,   1, 1);
      add(0, 0, B+0,  32'h0,         1, 0, 32'h020B040D,  0, 4'h8, 8'h30, 2'b10, 22'h20B,   22'h40D,   0, 1);
      add(0, 0, B+0,  32'h0,         1, 0, 32'h020B040D,  0, 4'h8, 8'h30, 2'b10, 22'h20B,   22'h40D,   0, 1);
      add(0, 0, B+0,  32'h0,         0, 0, 32'h020B040D,  0, 4'h8, 8'h30, 2'b10, 22'h20B,   22'h40D,   0, 1);
      // write coincident with vsync rise: old shadow commits, new write pends
      add(1, 0, B+16, 32'h00050006,  0, 1, 32'h020B040D,  0, 4'h8, 8'h30, 2'b10, 22'h20B,   22'h40D,   1, 1);
      add(1, 0, B+12, 32'h04010000,  1, 1, 32'h020B040D,  0, 4'h8, 8'h30, 2'b10, 22'h2A0B,  22'h340D,  1, 1);
      add(0, 0, B+0,  32'h0,         1, 0, 32'h020B040D,  0, 4'h8, 8'h30, 2'b10, 22'h2A0B,  22'h340D,  1, 1);
      add(0, 0, B+0,  32'h0,         0, 0, 32'h020B040D,  0, 4'h8, 8'h30, 2'b10, 22'h2A0B,  22'h340D,  1, 1);
      add(0, 0, B+0,  32'h0,         1, 0, 32'h020B040D,  0, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 1);
      add(0, 0, B+0,  32'h0,         0, 0, 32'h020B040D,  0, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 1);
      add(0, 1, B+0,  32'h0,         0, 1, 32'h00000001,  0, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 1);
      // force commit of game_state in frame-sync mode
      add(1, 0, B+0,  32'h50000003,  0, 1, 32'h00000001,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 1);
      add(0, 1, B+0,  32'h0,         0, 1, 32'h50000001,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 1);
      // out-of-range and misaligned accesses
      add(1, 0, B+20, 32'hFFFFFFFF,  0, 0, 32'h50000001,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 1);
      add(1, 0, B+2,  32'hFFFFFFFF,  0, 0, 32'h50000001,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 1);
      add(0, 1, B+20, 32'h0,         0, 0, 32'h50000001,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 1);
      add(0, 1, B+0,  32'h0,         0, 1, 32'h50000001,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 1);
      // simultaneous write and read: write lands, rdata held
      add(1, 1, B+8,  32'h00010002,  0, 1, 32'h50000001,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  1, 1);
      add(0, 1, B+8,  32'h0,         0, 1, 32'h00010002,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  1, 1);
      add(0, 1, B+0,  32'h0,         0, 1, 32'h50000003,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  1, 1);
      // back to mode 0: no commit by itself, the next write commits everything
      add(1, 0, B+0,  32'h50000000,  0, 1, 32'h50000003,  5, 4'h4, 8'h10, 2'b00, 22'h2A0B,  22'h340D,  0, 0);
      add(1, 0, B+4,  32'h00000001,  0, 1, 32'h50000003,  5, 4'h4, 8'h10, 2'b01, 22'h2801,  22'h3002,  0, 0);

      drive(0, 0, 32'h0, 32'h0, 0);
      repeat (2) @(posedge clk);
      #1;
      zero_v = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 3'h0, 4'h0, 8'h0,
                 2'b00, 22'h0, 22'h0, 1'b0, 1'b0};
      check_all("reset", zero_v);
      @(negedge clk);
      nrst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].vs);
         @(posedge clk);
         #1;
         $display("[TB] vec %0d wr=%0b rd=%0b addr=%h wdata=%h vs=%0b -> ack=%0b rdata=%h gs=%0d dirty=%0b mode=%0b",
                  i, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].vs,
                  bus.ack, bus.rdata, game_state, dirty, frame_sync_mode);
         check_all($sformatf("v%0d", i), vecs[i]);
      end

      // asynchronous reset while a write is acknowledged and data is pending
      @(negedge clk);
      drive(1, 0, B+0, 32'h1, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      drive(1, 0, B+4, 32'h0C000000, 0);
      @(posedge clk);
      #1;
      $display("[TB] pre-reset write: ack=%0b dirty=%0b mode=%0b", bus.ack, dirty, frame_sync_mode);
      chk("prerst ack",   32'(bus.ack), 32'h1);
      chk("prerst dirty", 32'(dirty),   32'h1);
      #2;
      nrst = 1'b0;
      #1;
      $display("[TB] async reset: ack=%0b dirty=%0b mode=%0b rdata=%h", bus.ack, dirty, frame_sync_mode, bus.rdata);
      check_all("asyncrst", zero_v);
      drive(0, 0, 32'h0, 32'h0, 0);
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
